param_memory: RTL and testbench
===============================

PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 16: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-004 Parameter WAIT_CYCLES, default 0: extra access wait states; legal range 0..15.
REQ-005 Parameter CLEAR_ON_RESET, default 1: 1 = zero the array after reset, 0 = retain contents.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_WIDTH  word address.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 req_wstrb  input  DATA_WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
REQ-014 resp_valid  output  1  response present.
REQ-015 resp_ready  input  1  consumer accepts the response.
REQ-016 resp_rdata  output  DATA_WIDTH  read data, or the merged written word for writes.
REQ-017 init_done  output  1  array is usable; requests are accepted only while high.

Function
REQ-018 The FSM SHALL have states CLEAR, IDLE, WAIT, ACCESS and RESP.
REQ-019 CLEAR: one word per cycle SHALL be zeroed at addresses 0..2**ADDR_WIDTH-1 in ascending order; the state SHALL go to IDLE on the edge that writes the last address, which SHALL also raise init_done.
REQ-020 With CLEAR_ON_RESET=0, the block SHALL leave reset in IDLE with init_done=1, and no array write SHALL occur.
REQ-021 req_ready SHALL be 1 only in IDLE; a handshake is req_valid&&req_ready at a rising edge.
REQ-022 On handshake, req_write, req_addr, req_wdata and req_wstrb SHALL be latched, and the state SHALL go to WAIT if WAIT_CYCLES>0, else to ACCESS.
REQ-023 WAIT SHALL last exactly WAIT_CYCLES cycles, then go to ACCESS.
REQ-024 On the ACCESS edge, a write SHALL update only the strobed bytes, and resp_rdata SHALL load the resulting full word.
REQ-025 On the ACCESS edge, a read SHALL load resp_rdata with the stored word.
REQ-026 The ACCESS edge SHALL set resp_valid=1 and move the state to RESP.
REQ-027 Latency: for a handshake at edge N, resp_valid SHALL first be high after edge N+1+WAIT_CYCLES.
REQ-028 In RESP, resp_valid and resp_rdata SHALL hold stable until resp_valid&&resp_ready at an edge, which SHALL clear resp_valid and return the state to IDLE.
REQ-029 At most one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored, with no side effects.
REQ-030 A write with req_wstrb all-zero SHALL leave the array unchanged and still complete a response carrying the unchanged word.
REQ-031 The array SHALL be modified only by CLEAR or by the ACCESS edge of a write; latched request fields SHALL NOT change between handshake and RESP exit.
REQ-032 The first request after a response SHALL be accepted no earlier than the cycle after the response handshake (IDLE cycle).

Reset
REQ-033 While reset=1: req_ready=0, resp_valid=0, resp_rdata=0, init_done=0, and the wait counter and clear counter SHALL be 0.
REQ-034 On reset release, the state SHALL be CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-035 Reset asserted mid-operation SHALL abort the transaction; a write whose ACCESS edge has not occurred SHALL NOT be committed.
REQ-036 The array SHALL NOT be modified by reset itself; with CLEAR_ON_RESET=0, contents SHALL survive reset.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, WAIT_CYCLES=2 unless stated)
REQ-037 Reset release with CLEAR_ON_RESET=1 -> init_done=1 after exactly 16 edges and req_ready=1; a read of 0x7 returns 0x0000.
REQ-038 Write 0xBEEF to 0x3 with wstrb=2'b11, handshake at edge N -> resp_valid rises after edge N+3 with resp_rdata=0xBEEF; a later read of 0x3 returns 0xBEEF.
REQ-039 Write 0x1234 to 0x3 (holding 0xBEEF) with wstrb=2'b10 -> response 0x12EF; wstrb=2'b00 -> response 0x12EF and contents unchanged.
REQ-040 Hold resp_ready=0 for 5 cycles during RESP while driving req_valid=1 -> resp_valid and resp_rdata stay stable, req_ready=0, and no second access occurs.
REQ-041 With CLEAR_ON_RESET=0, write 0xAAAA to 0x5, then write 0x5555 to 0x5 and assert reset during WAIT -> after release, a read of 0x5 returns 0xAAAA.
REQ-042 With WAIT_CYCLES=0, back-to-back reads with resp_ready=1 -> each response appears one edge after its handshake, and a new handshake occurs every 3 cycles.

Source files
------------

// File: rtl/param_memory.sv
// param_memory
//   Single-port word memory behind a valid/ready request/response handshake.
//   After reset the array can optionally be swept to zero (one word per
//   cycle); each accepted request then passes through WAIT_CYCLES wait
//   states, an ACCESS cycle that reads or byte-merges and writes the word,
//   and a RESP state that holds the result until the consumer takes it.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_write               1 = write, 0 = read
//   req_addr                word address
//   req_wdata, req_wstrb    write data and per-byte write enables
//   resp_valid / resp_ready response handshake
//   resp_rdata              read word, or the merged word after a write
//   init_done               array usable; requests accepted only while high
module param_memory #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int WAIT_CYCLES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    // Last value of the wait counter; unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  init_done_q, init_done_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] merged;
    logic                  handshake;

    assign mem_rd = mem[addr_q];

    // Stored word with the strobed bytes replaced by the latched write data.
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign merged[8*gi +: 8] = wstrb_q[gi] ? wdata_q[8*gi +: 8] : mem_rd[8*gi +: 8];
    end

    // Status outputs are gated by reset so they read 0 while reset is held
    // even in the no-clear configuration, whose reset state is already IDLE.
    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign init_done  = init_done_q && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign handshake  = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        init_done_d  = init_done_q;
        mem_we       = 1'b0;
        mem_waddr    = clr_cnt_q;
        mem_wdata    = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    clr_cnt_d   = '0;
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (handshake) begin
                    wr_d       = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wstrb_d    = req_wstrb;
                    wait_cnt_d = '0;
                    state_d    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ACCESS: begin
                if (wr_q) begin
                    // An all-zero strobe skips the write; the response still
                    // carries the unchanged word.
                    mem_we       = |wstrb_q;
                    mem_waddr    = addr_q;
                    mem_wdata    = merged;
                    resp_rdata_d = merged;
                end else begin
                    resp_rdata_d = mem_rd;
                end
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            wait_cnt_q   <= '0;
            clr_cnt_q    <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            init_done_q  <= (CLEAR_ON_RESET == 0);
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            init_done_q  <= init_done_d;
        end
    end

    // The array has no reset; contents survive reset and are only changed
    // by the clear sweep or by a write's ACCESS cycle.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory
//   Three instances share the clock: 0 = WAIT 2 / clear on reset,
//   1 = WAIT 2 / retain contents, 2 = WAIT 0 / clear on reset.
//   Requests push their expected response into a queue; a monitor pops and
//   compares on every response handshake.
module tb_param_memory;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0]         rst;
    logic [ND-1:0]         req_valid;
    logic [ND-1:0]         req_ready;
    logic [ND-1:0]         req_write;
    logic [ND-1:0][AW-1:0] req_addr;
    logic [ND-1:0][DW-1:0] req_wdata;
    logic [ND-1:0][1:0]    req_wstrb;
    logic [ND-1:0]         resp_valid;
    logic [ND-1:0]         resp_ready;
    logic [ND-1:0][DW-1:0] resp_rdata;
    logic [ND-1:0]         init_done;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        param_memory #(
            .DATA_WIDTH    (DW),
            .ADDR_WIDTH    (AW),
            .WAIT_CYCLES   ((gi == 2) ? 0 : 2),
            .CLEAR_ON_RESET((gi == 1) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[gi]),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_write (req_write[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .req_wstrb (req_wstrb[gi]),
            .resp_valid(resp_valid[gi]),
            .resp_ready(resp_ready[gi]),
            .resp_rdata(resp_rdata[gi]),
            .init_done (init_done[gi])
        );
    end

    typedef struct {
        int            dut;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a response is consumed on the next edge when valid && ready.
    always @(negedge clk) begin
        #1;
        for (int d = 0; d < ND; d++) begin
            if (resp_valid[d] && resp_ready[d]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: dut %0d got %h, required no response", d, resp_rdata[d]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_dut", d, e.dut);
                    check("resp_data", {16'h0, resp_rdata[d]}, {16'h0, e.data});
                    $display("txn dut=%0d rdata=%h expected=%h", d, resp_rdata[d], e.data);
                end
            end
        end
    end

    // Issue one request (called at a negedge with the DUT idle or about to be).
    task automatic do_req(input int d, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [1:0] ws,
                          input logic [DW-1:0] exp_data, input int exp_lat,
                          output int hs_cyc);
        int   n;
        exp_t e;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_wstrb[d] = ws;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", {31'h0, req_ready[d]}, 32'h1);
        @(posedge clk);
        e.dut  = d;
        e.data = exp_data;
        exp_q.push_back(e);
        @(negedge clk);
        hs_cyc       = cyc;
        req_valid[d] = 1'b0;
        n = 0;
        while (!resp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
        n = 0;
        while (resp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resp_done", {31'h0, resp_valid[d]}, 32'h0);
    endtask

    initial begin
        int n, h0, h1, h2;
        rst        = '1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = '1;
        repeat (3) @(negedge clk);

        // Outputs while reset is held.
        for (int d = 0; d < ND; d++) begin
            check("rst_req_ready", {31'h0, req_ready[d]}, 32'h0);
            check("rst_resp_valid", {31'h0, resp_valid[d]}, 32'h0);
            check("rst_resp_rdata", {16'h0, resp_rdata[d]}, 32'h0);
            check("rst_init_done", {31'h0, init_done[d]}, 32'h0);
        end

        // Release: the retaining instance is usable at once, the clearing
        // ones after exactly 16 edges.
        rst = '0;
        #1;
        check("noclr_init_done", {31'h0, init_done[1]}, 32'h1);
        check("noclr_req_ready", {31'h0, req_ready[1]}, 32'h1);
        check("clr_init_low", {31'h0, init_done[0]}, 32'h0);
        n = 0;
        while (!init_done[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("clear_edges", n, 16);
        check("clr_req_ready", {31'h0, req_ready[0]}, 32'h1);
        check("clr2_init_done", {31'h0, init_done[2]}, 32'h1);

        // Basic reads/writes with byte strobes, two wait states.
        do_req(0, 1'b0, 4'h7, 16'h0000, 2'b00, 16'h0000, 3, h0);
        do_req(0, 1'b1, 4'h3, 16'hBEEF, 2'b11, 16'hBEEF, 3, h0);
        do_req(0, 1'b0, 4'h3, 16'h0000, 2'b00, 16'hBEEF, 3, h0);
        do_req(0, 1'b1, 4'h3, 16'h1234, 2'b10, 16'h12EF, 3, h0);
        do_req(0, 1'b1, 4'h3, 16'h5678, 2'b00, 16'h12EF, 3, h0);
        do_req(0, 1'b0, 4'h3, 16'h0000, 2'b00, 16'h12EF, 3, h0);
        do_req(0, 1'b1, 4'h4, 16'hC3A5, 2'b01, 16'h00A5, 3, h0);

        // Back-pressure: response held while a competing write is offered.
        resp_ready[0] = 1'b0;
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_addr[0]   = 4'h3;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        exp_q.push_back('{dut: 0, data: 16'h12EF});
        @(negedge clk);
        req_write[0] = 1'b1;
        req_addr[0]  = 4'h9;
        req_wdata[0] = 16'hFFFF;
        req_wstrb[0] = 2'b11;
        n = 0;
        while (!resp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", n, 3);
        repeat (5) begin
            @(negedge clk);
            check("bp_resp_valid", {31'h0, resp_valid[0]}, 32'h1);
            check("bp_resp_rdata", {16'h0, resp_rdata[0]}, 32'h12EF);
            check("bp_req_ready", {31'h0, req_ready[0]}, 32'h0);
        end
        resp_ready[0] = 1'b1;
        req_valid[0]  = 1'b0;
        @(negedge clk);
        check("bp_resp_clear", {31'h0, resp_valid[0]}, 32'h0);
        repeat (4) @(negedge clk);
        check("bp_no_second", {31'h0, resp_valid[0]}, 32'h0);
        do_req(0, 1'b0, 4'h9, 16'h0000, 2'b00, 16'h0000, 3, h0);

        // Retaining instance: reset during WAIT aborts the second write.
        do_req(1, 1'b1, 4'h5, 16'hAAAA, 2'b11, 16'hAAAA, 3, h0);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 4'h5;
        req_wdata[1] = 16'h5555;
        req_wstrb[1] = 2'b11;
        n = 0;
        while (!req_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        #1;
        check("abort_resp_valid", {31'h0, resp_valid[1]}, 32'h0);
        check("abort_init_done", {31'h0, init_done[1]}, 32'h0);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        #1;
        check("abort_ready_after", {31'h0, req_ready[1]}, 32'h1);
        @(negedge clk);
        do_req(1, 1'b0, 4'h5, 16'h0000, 2'b00, 16'hAAAA, 3, h0);

        // Zero wait states: response one edge after handshake, a new
        // handshake every third cycle.
        do_req(2, 1'b1, 4'h2, 16'hA5A5, 2'b11, 16'hA5A5, 1, h0);
        do_req(2, 1'b0, 4'h2, 16'h0000, 2'b00, 16'hA5A5, 1, h1);
        do_req(2, 1'b0, 4'h7, 16'h0000, 2'b00, 16'h0000, 1, h2);
        check("b2b_spacing1", h1 - h0, 3);
        check("b2b_spacing2", h2 - h1, 3);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
